popcount_accum: RTL and testbench

//  Streaming, pipelined successor to the combinational popcount chain. Each accepted word contributes the

---
 rtl/popcount_pkg.sv | 31 +++
 rtl/popcount_tree.sv | 38 +++
 rtl/popcount_accum.sv | 122 ++++++++++++
 tb/tb_popcount_accum.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// Shared types and helpers for the streaming popcount accumulator.
package popcount_pkg;

    // Width needed to hold a count of 0..n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n + 1);
    endfunction

    localparam int unsigned CNT_W = 16;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        cnt_t cnt;
        logic last;
    } s1_t;

    // Saturating add at width w; bit 64 of the result flags that saturation occurred.
    function automatic logic [64:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [64:0] max;
        sum = {1'b0, a} + {1'b0, b};
        max = (w >= 64) ? {1'b0, {64{1'b1}}} : ((65'd1 << w) - 65'd1);
        if (sum > max) begin
            return {1'b1, max[63:0]};
        end
        return {1'b0, sum[63:0]};
    endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational masked popcount: counts the top n bits of data through a balanced adder tree.
module popcount_tree
    import popcount_pkg::*;
#(
    parameter int unsigned MAX_N   = 64,
    parameter int unsigned MAX_N_W = cnt_w(MAX_N)
) (
    input  logic [MAX_N-1:0]   data,
    input  logic [MAX_N_W-1:0] n,
    output cnt_t               cnt
);

    localparam int unsigned LEVELS = (MAX_N <= 1) ? 0 : $clog2(MAX_N);
    localparam int unsigned P      = 1 << LEVELS;
    localparam int unsigned CW     = cnt_w(MAX_N);

    logic [CW-1:0] node [LEVELS+1][P];

    always_comb begin
        for (int l = 0; l <= int'(LEVELS); l++) begin
            for (int j = 0; j < int'(P); j++) begin
                node[l][j] = '0;
            end
        end
        // Bit i is counted when it lies in the top n positions.
        for (int i = 0; i < int'(MAX_N); i++) begin
            node[0][i] = CW'(data[i] && (i + int'(n) >= int'(MAX_N)));
        end
        for (int l = 1; l <= int'(LEVELS); l++) begin
            for (int j = 0; j < int'(P >> l); j++) begin
                node[l][j] = node[l-1][2*j] + node[l-1][2*j+1];
            end
        end
    end

    assign cnt = cnt_t'(node[LEVELS][0]);

endmodule

// File: rtl/popcount_accum.sv
// Two-stage streaming popcount accumulator with saturating segment totals and valid/ready handshakes.
// Optional per-segment word count on out_words when POPCOUNT_ACCUM_WORDS_EN is defined.
module popcount_accum
    import popcount_pkg::*;
#(
    parameter int unsigned MAX_N   = 64,
    parameter int unsigned MAX_W   = 32,
    parameter int unsigned MAX_N_W = cnt_w(MAX_N)
`ifdef POPCOUNT_ACCUM_WORDS_EN
    ,
    parameter int unsigned WORDS_W = 16
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAX_N-1:0]   in_data,
    input  logic [MAX_N_W-1:0] in_n,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAX_W-1:0]   out_count,
`ifdef POPCOUNT_ACCUM_WORDS_EN
    output logic [WORDS_W-1:0] out_words,
`endif
    output logic               out_overflow
);

    logic [MAX_N_W-1:0] n_clamped;
    cnt_t               tree_cnt;
    s1_t                s1_q;
    logic               s1_valid_q;
    logic               s1_adv;
    logic               accept;
    logic [MAX_W-1:0]   acc_q;
    logic               acc_ovf_q;
    logic [64:0]        acc_sum;

    assign n_clamped = (in_n > MAX_N_W'(MAX_N)) ? MAX_N_W'(MAX_N) : in_n;

    popcount_tree #(
        .MAX_N   (MAX_N),
        .MAX_N_W (MAX_N_W)
    ) u_tree (
        .data (in_data),
        .n    (n_clamped),
        .cnt  (tree_cnt)
    );

    // Only a last word needs the output register free; non-last words always drain into acc.
    assign s1_adv   = s1_valid_q & (!s1_q.last | !out_valid | out_ready);
    assign in_ready = !s1_valid_q | s1_adv;
    assign accept   = in_valid & in_ready;
    assign acc_sum  = sat_add(64'(acc_q), 64'(s1_q.cnt), MAX_W);

    if (MAX_W < 64) begin : g_unused
        logic unused_acc_bits;
        assign unused_acc_bits = ^acc_sum[63:MAX_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q         <= '0;
            s1_valid_q   <= 1'b0;
            acc_q        <= '0;
            acc_ovf_q    <= 1'b0;
            out_valid    <= 1'b0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else begin
            if (accept) begin
                s1_q       <= '{cnt: tree_cnt, last: in_last};
                s1_valid_q <= 1'b1;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end

            if (s1_adv && s1_q.last) begin
                out_count    <= acc_sum[MAX_W-1:0];
                out_overflow <= acc_ovf_q | acc_sum[64];
                out_valid    <= 1'b1;
                acc_q        <= '0;
                acc_ovf_q    <= 1'b0;
            end else begin
                if (s1_adv) begin
                    acc_q     <= acc_sum[MAX_W-1:0];
                    acc_ovf_q <= acc_ovf_q | acc_sum[64];
                end
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

`ifdef POPCOUNT_ACCUM_WORDS_EN
    logic [WORDS_W-1:0] words_q;
    logic [64:0]        words_sum;
    logic               unused_words_bits;

    assign words_sum         = sat_add(64'(words_q), 64'd1, WORDS_W);
    assign unused_words_bits = ^words_sum[64:WORDS_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            words_q   <= '0;
            out_words <= '0;
        end else if (s1_adv) begin
            if (s1_q.last) begin
                out_words <= words_sum[WORDS_W-1:0];
                words_q   <= '0;
            end else begin
                words_q <= words_sum[WORDS_W-1:0];
            end
        end
    end
`else
    // No word counter in this build; out_words is absent.
`endif

endmodule

// File: tb/tb_popcount_accum.sv
// Directed self-checking bench for popcount_accum (MAX_N=8, MAX_W=4).
// Build with POPCOUNT_ACCUM_WORDS_EN defined to also check out_words.
module tb_popcount_accum;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] in_n;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_count;
    logic       out_overflow;
`ifdef POPCOUNT_ACCUM_WORDS_EN
    logic [15:0] out_words;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    popcount_accum #(
        .MAX_N (8),
        .MAX_W (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_n         (in_n),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_count    (out_count),
`ifdef POPCOUNT_ACCUM_WORDS_EN
        .out_words    (out_words),
`endif
        .out_overflow (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Present one word and hold it until accepted (bounded); returns 1 ns after the accept edge.
    task automatic send(input logic [7:0] d, input logic [3:0] n, input logic last);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_n     = n;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_accept: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    task automatic consume();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        in_n      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid);
        end
        n_cmp++;
        if (out_count !== 4'd0) begin
            n_fail++; $display("FAIL reset_out_count: got %0d required 0", out_count);
        end
        n_cmp++;
        if (out_overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_overflow: got %b required 0", out_overflow);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
`ifdef POPCOUNT_ACCUM_WORDS_EN
        n_cmp++;
        if (out_words !== 16'd0) begin
            n_fail++; $display("FAIL reset_out_words: got %0d required 0", out_words);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        bit seen;
        send(8'b1011_0000, 4'd4, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_early_valid: got %b required 0", out_valid);
        end
        wait_out(seen);
        n_cmp++;
        if (seen !== 1'b1) begin
            n_fail++; $display("FAIL single_timeout: out_valid seen=%b required 1", seen);
        end
        n_cmp++;
        if (out_count !== 4'd3) begin
            n_fail++; $display("FAIL single_count: got %0d required 3", out_count);
        end
        n_cmp++;
        if (out_overflow !== 1'b0) begin
            n_fail++; $display("FAIL single_overflow: got %b required 0", out_overflow);
        end
        consume();
    endtask

    task automatic test_segment();
        bit seen;
        send(8'hFF, 4'd8, 1'b0);
        send(8'hF0, 4'd2, 1'b0);
        send(8'h01, 4'd8, 1'b1);
        wait_out(seen);
        n_cmp++;
        if (seen !== 1'b1 || out_count !== 4'd11) begin
            n_fail++; $display("FAIL segment_count: valid=%b got %0d required 11", seen, out_count);
        end
        n_cmp++;
        if (out_overflow !== 1'b0) begin
            n_fail++; $display("FAIL segment_overflow: got %b required 0", out_overflow);
        end
`ifdef POPCOUNT_ACCUM_WORDS_EN
        n_cmp++;
        if (out_words !== 16'd3) begin
            n_fail++; $display("FAIL segment_words: got %0d required 3", out_words);
        end
`endif
        consume();
    endtask

    task automatic test_saturation();
        bit seen;
        send(8'hFF, 4'd8, 1'b0);
        send(8'hFF, 4'd8, 1'b1);
        wait_out(seen);
        n_cmp++;
        if (seen !== 1'b1 || out_count !== 4'd15) begin
            n_fail++; $display("FAIL sat_count: valid=%b got %0d required 15", seen, out_count);
        end
        n_cmp++;
        if (out_overflow !== 1'b1) begin
            n_fail++; $display("FAIL sat_overflow: got %b required 1", out_overflow);
        end
        consume();
        send(8'h80, 4'd1, 1'b1);
        wait_out(seen);
        n_cmp++;
        if (seen !== 1'b1 || out_count !== 4'd1) begin
            n_fail++; $display("FAIL sat_next_count: valid=%b got %0d required 1", seen, out_count);
        end
        n_cmp++;
        if (out_overflow !== 1'b0) begin
            n_fail++; $display("FAIL sat_next_overflow: got %b required 0", out_overflow);
        end
        consume();
    endtask

    task automatic test_backpressure();
        logic [3:0] got[$];
        bit         acc;
        out_ready = 1'b0;
        send(8'h0F, 4'd8, 1'b1);
        send(8'h0F, 4'd8, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h0F;
        in_n     = 4'd8;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_in_ready: cycle %0d got %b required 0", i, in_ready);
            end
            n_cmp++;
            if (out_valid !== 1'b1 || out_count !== 4'd4) begin
                n_fail++;
                $display("FAIL bp_hold: cycle %0d valid=%b count=%0d required 1/4", i, out_valid,
                         out_count);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            acc = in_valid & in_ready;
            if (out_valid && out_ready) got.push_back(out_count);
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
        end
        n_cmp++;
        if (got.size() != 3) begin
            n_fail++; $display("FAIL bp_total_count: got %0d totals required 3", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== 4'd4) begin
                n_fail++; $display("FAIL bp_value: total %0d got %0d required 4", i, got[i]);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_clamp();
        bit seen;
        send(8'hFF, 4'd15, 1'b1);
        wait_out(seen);
        n_cmp++;
        if (seen !== 1'b1 || out_count !== 4'd8) begin
            n_fail++; $display("FAIL clamp_count: valid=%b got %0d required 8", seen, out_count);
        end
        consume();
        send(8'hFF, 4'd0, 1'b1);
        wait_out(seen);
        n_cmp++;
        if (seen !== 1'b1 || out_count !== 4'd0) begin
            n_fail++; $display("FAIL zero_n_count: valid=%b got %0d required 0", seen, out_count);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        bit seen;
        send(8'hFF, 4'd8, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'h01, 4'd8, 1'b1);
        wait_out(seen);
        n_cmp++;
        if (seen !== 1'b1 || out_count !== 4'd1) begin
            n_fail++; $display("FAIL reset_mid_count: valid=%b got %0d required 1", seen, out_count);
        end
`ifdef POPCOUNT_ACCUM_WORDS_EN
        n_cmp++;
        if (out_words !== 16'd1) begin
            n_fail++; $display("FAIL reset_mid_words: got %0d required 1", out_words);
        end
`endif
        consume();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hF0;
        in_n      = 4'd8;
        in_last   = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready: got %b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_data = 8'h03;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_count !== 4'd4) begin
            n_fail++; $display("FAIL b2b_first: valid=%b count=%0d required 1/4", out_valid, out_count);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_count !== 4'd2) begin
            n_fail++; $display("FAIL b2b_second: valid=%b count=%0d required 1/2", out_valid, out_count);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drained: valid=%b required 0", out_valid);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_single();
        test_segment();
        test_saturation();
        test_backpressure();
        test_clamp();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
